mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The module SHALL have one clock and synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 opcode  input  6  instr[31:26] from the instruction register.
REQ-003 funct  input  6  instr[5:0] from the instruction register.
REQ-004 zero  input  1  ALU zero flag, valid in the same cycle as the subtract.
REQ-005 alu_op  output  4  ALU operation: 0000 add, 0010 sub, 0100 and, 0101 or.
REQ-006 alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-007 alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-008 Memory and IR controls SHALL be: iord  output  1  memory address select (0 = PC, 1 = ALUOut); mem_write  output  1; ir_write  output  1.
REQ-009 Register file controls SHALL be: reg_dst  output  1  (0 = rt, 1 = rd); mem_to_reg  output  1  (0 = ALUOut, 1 = MDR); reg_write  output  1.
REQ-010 PC controls SHALL be: pc_src  output  2  (00 = ALU result, 01 = ALUOut, 10 = jump target); pc_en  output  1  PC load enable.
REQ-011 state  output  4  current state encoding, for debug.
REQ-012 Parameter: none.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-014 Transitions from FETCH and DECODE SHALL be: FETCH->DECODE. DECODE goes to MEMADR for lw 100011 or sw 101011; EXEC for R-type 000000; BRANCH for beq 000100; ADDIEX for addi 001000; JUMP for j 000010. Any other opcode goes to FETCH.
REQ-015 Remaining transitions SHALL be: MEMADR->MEMRD for lw, MEMADR->MEMWR for sw; MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB. MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP all go to FETCH.
REQ-016 FETCH SHALL drive iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_src=00 and pc_en=1.
REQ-017 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=0000, computing the branch target.
REQ-018 Address and memory states SHALL drive: MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=0000. MEMRD: iord=1. MEMWR: iord=1, mem_write=1.
REQ-019 Writeback states SHALL drive: MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
REQ-020 EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op from funct: 100000->0000, 100010->0010, 100100->0100, 100101->0101.
REQ-021 For any other funct, EXEC SHALL drive alu_op=0000, and the following ALUWB SHALL drive reg_write=0. An unsupported funct produces no architectural write.
REQ-022 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=0010 and pc_src=01, with pc_en = zero combinationally in the same cycle.
REQ-023 JUMP SHALL drive pc_src=10 and pc_en=1.
REQ-024 Every output not listed for a state SHALL be 0. All outputs except pc_en SHALL be decoded from state only (Moore).
REQ-025 Instruction latencies SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; illegal opcode 2 cycles.
REQ-026 The funct value used by ALUWB SHALL be latched at EXEC, so that an IR change cannot alter the writeback.

Reset
REQ-027 On a clk edge with reset=1, state SHALL become FETCH.
REQ-028 While reset=1, pc_en, ir_write, mem_write and reg_write SHALL be forced to 0.
REQ-029 A reset asserted in any state, including mid-instruction, SHALL abort the instruction with no further write.
REQ-030 After reset is deasserted, the first FETCH SHALL occur in the next cycle.

Structure
REQ-031 A shared package SHALL hold the state encodings, opcode constants, funct constants and ALU op codes 0000/0010/0100/0101; the ALU uses the same package.
REQ-032 One sub-module, alu_decoder (funct plus a state class in, alu_op out), is natural. Next-state logic and output decode stay in mc_control_fsm.

Verification
REQ-033 Release reset, hold opcode=100011 (lw) -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-034 R-type with funct=100010 -> alu_op=0010 in EXEC and reg_write=1 with reg_dst=1 in ALUWB; repeat with funct=101010 -> reg_write=0 in ALUWB.
REQ-035 beq with zero=1 -> pc_en=1 and pc_src=01 in BRANCH; with zero=0 -> pc_en=0; both return to FETCH next cycle.
REQ-036 opcode=111111 -> state sequence FETCH, DECODE, FETCH with no write enable asserted outside FETCH.
REQ-037 sw, with reset asserted during MEMADR -> next state FETCH, mem_write never 1, pc_en=0 during the reset cycle.
REQ-038 j -> pc_src=10 and pc_en=1 in JUMP, 3-cycle instruction.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - shared state, opcode, funct and ALU op encodings
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Which ALU operation family the current state needs
  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_FUNCT = 2'd2
  } alu_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for the R-type functions the datapath actually implements
  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// rtl/mc_control_fsm_alu_decoder.sv - maps state class and funct to the ALU op code
module alu_decoder
  import mc_control_fsm_pkg::*;
(
  input  logic [5:0] funct_i,
  input  alu_cls_t   alu_cls_i,
  output logic [3:0] alu_op_o
);

  // Unsupported funct falls back to add; writeback is suppressed elsewhere
  always_comb begin
    alu_op_o = ALU_ADD;
    case (alu_cls_i)
      ALU_CLS_SUB: alu_op_o = ALU_SUB;
      ALU_CLS_FUNCT: begin
        case (funct_i)
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS-subset control state machine
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [5:0] funct_q;
  alu_cls_t   alu_cls;

  // State register; funct is captured in EXEC so ALUWB ignores later IR changes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) funct_q <= funct;
    end
  end

  // Next-state decode from current state and opcode
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct_i   (funct),
    .alu_cls_i (alu_cls),
    .alu_op_o  (alu_op)
  );

  // Moore output decode; pc_en alone sees zero, and reset gates every write enable
  always_comb begin
    alu_cls    = ALU_CLS_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_src     = PCSRC_ALU;
    pc_en      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
      end
      S_DECODE: alu_src_b = SRCB_IMM2;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_cls   = ALU_CLS_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = funct_supported(funct_q);
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_cls   = ALU_CLS_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized model-checked bench for mc_control_fsm
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, pc_en;
  logic [1:0] pc_src;
  logic [3:0] state;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .pc_src(pc_src), .pc_en(pc_en), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          obs_state [8];
  logic [15:0] obs_word  [8];
  int          obs_len;

  // Control word layout: {alu_op, src_a, src_b, iord, mem_write, ir_write,
  // reg_dst, mem_to_reg, reg_write, pc_src, pc_en}
  function automatic logic [15:0] pw(logic [3:0] op, logic a, logic [1:0] b,
                                     logic io, logic mw, logic iw, logic rd,
                                     logic mr, logic rw, logic [1:0] ps, logic pe);
    return {op, a, b, io, mw, iw, rd, mr, rw, ps, pe};
  endfunction

  function automatic int lat(logic [5:0] op);
    case (op)
      6'b100011:                       return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010:            return 3;
      default:                         return 2;
    endcase
  endfunction

  // State visited at cycle k of an instruction with this opcode
  function automatic int step_state(logic [5:0] op, int k);
    if (k < 2) return k;
    case (op)
      6'b100011: return (k == 2) ? 2 : (k == 3) ? 3 : 4;
      6'b101011: return (k == 2) ? 2 : 5;
      6'b000000: return (k == 2) ? 6 : 7;
      6'b001000: return (k == 2) ? 9 : 10;
      6'b000100: return 8;
      6'b000010: return 11;
      default:   return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_alu(logic [5:0] f);
    case (f)
      6'b100010: return 4'b0010;
      6'b100100: return 4'b0100;
      6'b100101: return 4'b0101;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic model_ok(logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) || (f == 6'b100101);
  endfunction

  function automatic logic [15:0] model_word(int st, logic [5:0] f_now, logic [5:0] f_exec,
                                             logic z, logic rst);
    logic [15:0] w;
    case (st)
      0:  w = pw(4'b0000, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1);
      1:  w = pw(4'b0000, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      2:  w = pw(4'b0000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      3:  w = pw(4'b0000, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0);
      4:  w = pw(4'b0000, 0, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00, 0);
      5:  w = pw(4'b0000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0);
      6:  w = pw(model_alu(f_now), 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      7:  w = pw(4'b0000, 0, 2'b00, 0, 0, 0, 1, 0, model_ok(f_exec), 2'b00, 0);
      8:  w = pw(4'b0010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, z);
      9:  w = pw(4'b0000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      10: w = pw(4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0);
      default: w = pw(4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1);
    endcase
    if (rst) w = w & ~16'h00C9;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction, checking every cycle; rst_step >= 0 asserts reset in that cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int rst_step, input bit fchange);
    logic [5:0]  f_exec;
    logic [15:0] dw, ew;
    int          st;
    int          n;
    f_exec = fn;
    n = lat(op);
    obs_len = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = (k == rst_step);
      if (k == 0) begin
        opcode = op;
        funct  = fn;
      end
      st = step_state(op, k);
      if (fchange && st == 7) funct = 6'($urandom);
      zero = (zmode == 2) ? 1'($urandom) : zmode[0];
      #1;
      if (st == 6) f_exec = funct;
      ew = model_word(st, funct, f_exec, zero, reset);
      dw = {alu_op, alu_src_a, alu_src_b, iord, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write, pc_src, pc_en};
      check("state", 32'(state), 32'(st));
      check("ctl_word", 32'(dw), 32'(ew));
      obs_state[k] = int'(state);
      obs_word[k]  = dw;
      obs_len = k + 1;
      if (reset) break;
    end
  endtask

  int          lw_seq [5] = '{0, 1, 2, 3, 4};
  int          j_seq  [3] = '{0, 1, 11};
  logic [5:0]  ops    [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0]  fns    [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};

  initial begin
    logic [5:0] op, fn;
    int rs;

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_wr_en", 32'({pc_en, ir_write, mem_write, reg_write}), 32'd0);

    run_instr(6'b100011, 6'b000000, 2, -1, 1'b0);
    check("lw_len", 32'(obs_len), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("lw_seq", 32'(obs_state[i]), 32'(lw_seq[i]));
      check("lw_reg_write", 32'(obs_word[i][3]), 32'(i == 4));
      check("lw_mem_to_reg", 32'(obs_word[i][4]), 32'(i == 4));
    end

    run_instr(6'b000000, 6'b100010, 2, -1, 1'b0);
    check("sub_alu_op", 32'(obs_word[2][15:12]), 32'h2);
    check("sub_reg_write", 32'(obs_word[3][3]), 32'd1);
    check("sub_reg_dst", 32'(obs_word[3][5]), 32'd1);

    run_instr(6'b000000, 6'b101010, 2, -1, 1'b1);
    check("slt_reg_write", 32'(obs_word[3][3]), 32'd0);

    run_instr(6'b000100, 6'b000000, 1, -1, 1'b0);
    check("beq_t_pc_en", 32'(obs_word[2][0]), 32'd1);
    check("beq_t_pc_src", 32'(obs_word[2][2:1]), 32'd1);
    run_instr(6'b000100, 6'b000000, 0, -1, 1'b0);
    check("beq_nt_pc_en", 32'(obs_word[2][0]), 32'd0);

    run_instr(6'b111111, 6'b000000, 2, -1, 1'b0);
    check("ill_state", 32'(obs_state[1]), 32'd1);
    check("ill_no_write", 32'(obs_word[1] & 16'h00C9), 32'd0);

    run_instr(6'b101011, 6'b000000, 2, 2, 1'b0);
    check("sw_rst_len", 32'(obs_len), 32'd3);
    check("sw_rst_pc_en", 32'(obs_word[2][0]), 32'd0);
    check("sw_rst_mem_write", 32'(obs_word[2][7]), 32'd0);

    run_instr(6'b000010, 6'b000000, 2, -1, 1'b0);
    for (int i = 0; i < 3; i++) check("j_seq", 32'(obs_state[i]), 32'(j_seq[i]));
    check("j_pc_src", 32'(obs_word[2][2:1]), 32'd2);
    check("j_pc_en", 32'(obs_word[2][0]), 32'd1);

    for (int t = 0; t < 300; t++) begin
      op = ($urandom_range(0, 6) == 6) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 4) == 4) ? 6'($urandom) : fns[$urandom_range(0, 3)];
      rs = ($urandom_range(0, 11) == 0) ? $urandom_range(0, lat(op) - 1) : -1;
      run_instr(op, fn, 2, rs, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
